// File: rtl/spi_mem_ctrl.sv
// SPI mode-0 memory controller: issues read (0x03) / write (0x02) of 1, 2 or 4 bytes,
// little-endian, with a programmable SCLK divider and CS setup/hold, all on clk.
module spi_mem_ctrl #(
    parameter int ADDR_W   = 24,
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 5,
    parameter int CS_HOLD  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              write_en,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              busy,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              cs
);

    localparam int TX_W    = 8 + ADDR_W + 32;
    localparam int CNT_MAX = (CLK_DIV > CS_SETUP)
                           ? ((CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD)
                           : ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_DONE
    } state_t;

    state_t            r_state, w_stateNext;
    logic [CNT_W-1:0]  r_cnt, w_cntNext;
    logic [6:0]        r_bitCnt, w_bitCntNext;
    logic [TX_W-1:0]   r_tx, w_txNext, w_txLoad;
    logic [31:0]       r_rx, w_rxNext;
    logic [31:0]       r_rdata, w_rdataNext, w_rdataAsm;
    logic              r_sclk, w_sclkNext;
    logic              r_mosi, w_mosiNext;
    logic              r_cs, w_csNext;
    logic              r_done, w_doneNext;
    logic              r_writeEn, w_writeEnNext;
    logic [1:0]        r_size, w_sizeNext;
    logic              r_abort, w_abortNext;

    function automatic logic [6:0] dataBits(input logic [1:0] s);
        case (s)
            2'd0:    return 7'd8;
            2'd1:    return 7'd16;
            default: return 7'd32;
        endcase
    endfunction

    // Data bytes are placed byte0-first so the MSB-first shifter emits them little-endian.
    assign w_txLoad = {write_en ? 8'h02 : 8'h03, addr,
                       write_en ? {wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24]} : 32'h0};

    always_comb begin
        w_rdataAsm = 32'h0;
        if (!r_writeEn) begin
            case (r_size)
                2'd0:    w_rdataAsm = {24'h0, r_rx[7:0]};
                2'd1:    w_rdataAsm = {16'h0, r_rx[7:0], r_rx[15:8]};
                default: w_rdataAsm = {r_rx[7:0], r_rx[15:8], r_rx[23:16], r_rx[31:24]};
            endcase
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_cntNext     = r_cnt;
        w_bitCntNext  = r_bitCnt;
        w_txNext      = r_tx;
        w_rxNext      = r_rx;
        w_rdataNext   = r_rdata;
        w_sclkNext    = r_sclk;
        w_mosiNext    = r_mosi;
        w_csNext      = r_cs;
        w_doneNext    = 1'b0;
        w_writeEnNext = r_writeEn;
        w_sizeNext    = r_size;
        w_abortNext   = r_abort;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_stateNext   = S_SETUP;
                    w_cntNext     = '0;
                    w_writeEnNext = write_en;
                    w_sizeNext    = size;
                    w_txNext      = w_txLoad;
                    w_bitCntNext  = 7'(8 + ADDR_W - 1) + dataBits(size);
                    w_rxNext      = '0;
                    w_rdataNext   = '0;
                    w_abortNext   = 1'b0;
                    w_csNext      = 1'b0;
                    w_sclkNext    = 1'b0;
                    w_mosiNext    = w_txLoad[TX_W-1];
                end
            end

            S_SETUP: begin
                if (!start) begin
                    w_stateNext = S_HOLD;
                    w_cntNext   = '0;
                    w_sclkNext  = 1'b0;
                    w_mosiNext  = 1'b0;
                    w_abortNext = 1'b1;
                end else if (r_cnt == CNT_W'(CS_SETUP - 1)) begin
                    w_stateNext = S_SHIFT;
                    w_cntNext   = '0;
                end else begin
                    w_cntNext = r_cnt + 1'b1;
                end
            end

            // Rising SCLK samples miso (data phase of reads only); falling SCLK advances mosi.
            S_SHIFT: begin
                if (!start) begin
                    w_stateNext = S_HOLD;
                    w_cntNext   = '0;
                    w_sclkNext  = 1'b0;
                    w_mosiNext  = 1'b0;
                    w_abortNext = 1'b1;
                end else if (r_cnt == CNT_W'(CLK_DIV - 1)) begin
                    w_cntNext = '0;
                    if (!r_sclk) begin
                        w_sclkNext = 1'b1;
                        if (!r_writeEn && (r_bitCnt < dataBits(r_size)))
                            w_rxNext = {r_rx[30:0], miso};
                    end else begin
                        w_sclkNext = 1'b0;
                        if (r_bitCnt == 7'd0) begin
                            w_stateNext = S_HOLD;
                            w_mosiNext  = 1'b0;
                        end else begin
                            w_txNext     = {r_tx[TX_W-2:0], 1'b0};
                            w_mosiNext   = r_tx[TX_W-2];
                            w_bitCntNext = r_bitCnt - 1'b1;
                        end
                    end
                end else begin
                    w_cntNext = r_cnt + 1'b1;
                end
            end

            S_HOLD: begin
                w_abortNext = r_abort | ~start;
                if (r_cnt == CNT_W'(CS_HOLD - 1)) begin
                    w_cntNext = '0;
                    w_csNext  = 1'b1;
                    if (r_abort || !start) begin
                        w_stateNext = S_IDLE;
                    end else begin
                        w_stateNext = S_DONE;
                        w_rdataNext = w_rdataAsm;
                    end
                end else begin
                    w_cntNext = r_cnt + 1'b1;
                end
            end

            S_DONE: begin
                if (start)
                    w_doneNext = 1'b1;
                else
                    w_stateNext = S_IDLE;
            end

            default: w_stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bitCnt  <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_rdata   <= '0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_cs      <= 1'b1;
            r_done    <= 1'b0;
            r_writeEn <= 1'b0;
            r_size    <= '0;
            r_abort   <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_cnt     <= w_cntNext;
            r_bitCnt  <= w_bitCntNext;
            r_tx      <= w_txNext;
            r_rx      <= w_rxNext;
            r_rdata   <= w_rdataNext;
            r_sclk    <= w_sclkNext;
            r_mosi    <= w_mosiNext;
            r_cs      <= w_csNext;
            r_done    <= w_doneNext;
            r_writeEn <= w_writeEnNext;
            r_size    <= w_sizeNext;
            r_abort   <= w_abortNext;
        end
    end

    assign rdata = r_rdata;
    assign done  = r_done;
    assign busy  = (r_state == S_SETUP) || (r_state == S_SHIFT) || (r_state == S_HOLD);
    assign sclk  = r_sclk;
    assign mosi  = r_mosi;
    assign cs    = r_cs;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Directed bench for spi_mem_ctrl: default instance plus a CLK_DIV=1 instance,
// each with a small SPI slave model that records mosi and serves read bytes.
module tb_spi_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        startF = 1'b0;
    logic        write_en = 1'b0;
    logic [1:0]  size = 2'd0;
    logic [23:0] addr = 24'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata, rdataF;
    logic        done, busy, sclk, mosi, miso, cs;
    logic        doneF, busyF, sclkF, mosiF, misoF, csF;

    logic [31:0]  respWord = 32'h0;
    int           riseCnt = 0, riseCntF = 0;
    logic [127:0] mosiShift = '0, mosiShiftF = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_mem_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .write_en(write_en), .size(size),
        .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .busy(busy),
        .sclk(sclk), .mosi(mosi), .miso(miso), .cs(cs)
    );

    spi_mem_ctrl #(.ADDR_W(24), .CLK_DIV(1), .CS_SETUP(5), .CS_HOLD(8)) dutFast (
        .clk(clk), .rst(rst), .start(startF), .write_en(write_en), .size(size),
        .addr(addr), .wdata(wdata), .rdata(rdataF), .done(doneF), .busy(busyF),
        .sclk(sclkF), .mosi(mosiF), .miso(misoF), .cs(csF)
    );

    // Slave serves respWord MSB-first once the 32 command/address bits have gone by.
    function automatic logic misoBit(input int rc, input logic [31:0] w);
        if (rc >= 32 && rc < 64) return w[5'(63 - rc)];
        return 1'b0;
    endfunction

    assign miso  = misoBit(riseCnt, respWord);
    assign misoF = misoBit(riseCntF, respWord);

    always @(posedge sclk) begin
        mosiShift = {mosiShift[126:0], mosi};
        riseCnt = riseCnt + 1;
    end
    always @(negedge cs) begin
        riseCnt = 0;
        mosiShift = '0;
    end
    always @(posedge sclkF) begin
        mosiShiftF = {mosiShiftF[126:0], mosiF};
        riseCntF = riseCntF + 1;
    end
    always @(negedge csF) begin
        riseCntF = 0;
        mosiShiftF = '0;
    end

    // Launch a transaction and count edges from the one that samples start until done.
    // Inputs are scrambled right after that edge to show they are no longer looked at.
    task automatic applyStimulus(input bit sel, input logic we, input logic [1:0] sz,
                                 input logic [23:0] ad, input logic [31:0] wd,
                                 output int lat, output bit timedOut);
        int n;
        @(negedge clk);
        write_en = we; size = sz; addr = ad; wdata = wd;
        if (sel) startF = 1'b1; else start = 1'b1;
        n = 0;
        timedOut = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                write_en = ~we; size = ~sz; addr = ~ad; wdata = ~wd;
            end
            if ((sel ? doneF : done) === 1'b1) begin
                timedOut = 1'b0;
                break;
            end
        end
        lat = n - 1;
    endtask

    task automatic dropStart();
        @(negedge clk);
        start = 1'b0;
        startF = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (cs !== 1'b1) begin errors++; $display("FAIL reset_cs got %b want 1", cs); end
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b want 0", sclk); end
        checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b want 0", mosi); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Two-byte read at 0x000100.
    task automatic test_read2();
        int lat; bit to;
        respWord = 32'h11223344;
        applyStimulus(1'b0, 1'b0, 2'd1, 24'h000100, 32'h0, lat, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL read2_timeout done never rose"); end
        checks++; if (lat !== 398) begin errors++; $display("FAIL read2_latency got %0d want 398", lat); end
        checks++; if (rdata !== 32'h00002211) begin errors++; $display("FAIL read2_rdata got %h want 00002211", rdata); end
        checks++; if (mosiShift[47:0] !== 48'h030001000000) begin errors++; $display("FAIL read2_mosi got %h want 030001000000", mosiShift[47:0]); end
        checks++; if (riseCnt !== 48) begin errors++; $display("FAIL read2_rises got %0d want 48", riseCnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read2_busy got %b want 0", busy); end
        dropStart();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL read2_done_clear got %b want 0", done); end
    endtask

    task automatic test_write();
        int lat; bit to;
        respWord = 32'hFFFFFFFF;
        applyStimulus(1'b0, 1'b1, 2'd1, 24'h000010, 32'h1234BEEF, lat, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL write_timeout done never rose"); end
        checks++; if (lat !== 398) begin errors++; $display("FAIL write_latency got %0d want 398", lat); end
        checks++; if (mosiShift[47:0] !== 48'h02000010EFBE) begin errors++; $display("FAIL write_mosi got %h want 02000010EFBE", mosiShift[47:0]); end
        checks++; if (riseCnt !== 48) begin errors++; $display("FAIL write_rises got %0d want 48", riseCnt); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL write_rdata got %h want 0", rdata); end
        dropStart();
    endtask

    task automatic test_read1_top_addr();
        int lat; bit to;
        respWord = 32'hA5000000;
        applyStimulus(1'b0, 1'b0, 2'd0, 24'hFFFFFF, 32'h0, lat, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL read1_timeout done never rose"); end
        checks++; if (lat !== 334) begin errors++; $display("FAIL read1_latency got %0d want 334", lat); end
        checks++; if (rdata !== 32'h000000A5) begin errors++; $display("FAIL read1_rdata got %h want 000000A5", rdata); end
        checks++; if (mosiShift[39:0] !== 40'h03FFFFFF00) begin errors++; $display("FAIL read1_mosi got %h want 03FFFFFF00", mosiShift[39:0]); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read1_busy got %b want 0", busy); end
        dropStart();
    endtask

    task automatic test_abort();
        int lat, n; bit to, doneSeen, reached;
        respWord = 32'hDEADBEEF;
        @(negedge clk);
        write_en = 1'b0; size = 2'd2; addr = 24'h123456; start = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (riseCnt >= 20) begin reached = 1'b1; break; end
        end
        checks++; if (reached !== 1'b1) begin errors++; $display("FAIL abort_wait_rises got %0d want 20", riseCnt); end
        start = 1'b0;
        @(posedge clk); #1;
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL abort_sclk_stop got %b want 0", sclk); end
        n = 0; doneSeen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            n++;
            if (done === 1'b1) doneSeen = 1'b1;
            if (cs === 1'b1) break;
        end
        checks++; if (n !== 8) begin errors++; $display("FAIL abort_hold_len got %0d want 8", n); end
        checks++; if (doneSeen !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", doneSeen); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL abort_rdata got %h want 0", rdata); end
        checks++; if (riseCnt !== 20) begin errors++; $display("FAIL abort_rises got %0d want 20", riseCnt); end
        applyStimulus(1'b0, 1'b0, 2'd2, 24'h123456, 32'h0, lat, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL after_abort_timeout done never rose"); end
        checks++; if (lat !== 526) begin errors++; $display("FAIL after_abort_latency got %0d want 526", lat); end
        checks++; if (rdata !== 32'hEFBEADDE) begin errors++; $display("FAIL after_abort_rdata got %h want EFBEADDE", rdata); end
        checks++; if (mosiShift[63:0] !== 64'h0312345600000000) begin errors++; $display("FAIL after_abort_mosi got %h want 0312345600000000", mosiShift[63:0]); end
        dropStart();
    endtask

    task automatic test_reset_mid_shift();
        int lat; bit to, reached;
        respWord = 32'h5A000000;
        @(negedge clk);
        write_en = 1'b1; size = 2'd2; addr = 24'h000777; wdata = 32'hCAFEF00D; start = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (riseCnt >= 10) begin reached = 1'b1; break; end
        end
        checks++; if (reached !== 1'b1) begin errors++; $display("FAIL rstmid_wait_rises got %0d want 10", riseCnt); end
        rst = 1'b1;
        #1;
        checks++; if ({cs, sclk, mosi, done, busy} !== 5'b10000) begin errors++; $display("FAIL rstmid_outputs got cs/sclk/mosi/done/busy=%b want 10000", {cs, sclk, mosi, done, busy}); end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 2'd0, 24'h000042, 32'h0, lat, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL rstmid_timeout done never rose"); end
        checks++; if (lat !== 334) begin errors++; $display("FAIL rstmid_latency got %0d want 334", lat); end
        checks++; if (rdata !== 32'h0000005A) begin errors++; $display("FAIL rstmid_rdata got %h want 0000005A", rdata); end
        dropStart();
    endtask

    task automatic test_hold_start();
        int lat, bad; bit to;
        respWord = 32'h11223344;
        applyStimulus(1'b0, 1'b0, 2'd1, 24'h000100, 32'h0, lat, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL hold_timeout done never rose"); end
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done !== 1'b1 || cs !== 1'b1 || sclk !== 1'b0 || rdata !== 32'h00002211) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL hold_stable got %0d bad cycles want 0", bad); end
        checks++; if (riseCnt !== 48) begin errors++; $display("FAIL hold_single_txn got %0d rises want 48", riseCnt); end
        dropStart();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL hold_done_clear got %b want 0", done); end
    endtask

    task automatic test_clk_div1();
        int lat; bit to;
        respWord = 32'h11223344;
        applyStimulus(1'b1, 1'b0, 2'd1, 24'h000100, 32'h0, lat, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL div1_timeout done never rose"); end
        checks++; if (lat !== 110) begin errors++; $display("FAIL div1_latency got %0d want 110", lat); end
        checks++; if (rdataF !== 32'h00002211) begin errors++; $display("FAIL div1_rdata got %h want 00002211", rdataF); end
        checks++; if (mosiShiftF[47:0] !== 48'h030001000000) begin errors++; $display("FAIL div1_mosi got %h want 030001000000", mosiShiftF[47:0]); end
        checks++; if (riseCntF !== 48) begin errors++; $display("FAIL div1_rises got %0d want 48", riseCntF); end
        dropStart();
    endtask

    initial begin
        test_reset();
        test_read2();
        test_write();
        test_read1_top_addr();
        test_abort();
        test_reset_mid_shift();
        test_hold_start();
        test_clk_div1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
